// File: rtl/vscale_dmem_arbiter.sv
// Round-robin HASTI arbiter merging N_CORES dmem master ports onto one shared slave port.
// Address phases are held across slave stalls. Responses for data-phase owners that are blocked get stashed.
module vscale_dmem_arbiter #(
  parameter  int unsigned N_CORES        = 4,
  parameter  int unsigned CORE_IDX_WIDTH = 2,
  localparam int unsigned ADDR_W         = 32,
  localparam int unsigned DATA_W         = 32,
  localparam int unsigned SIZE_W         = 3,
  localparam int unsigned TRANS_W        = 2,
  localparam int unsigned BURST_W        = 3,
  localparam int unsigned PROT_W         = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [N_CORES*ADDR_W-1:0]   m_haddr,
  input  logic [N_CORES-1:0]          m_hwrite,
  input  logic [N_CORES*SIZE_W-1:0]   m_hsize,
  input  logic [N_CORES*TRANS_W-1:0]  m_htrans,
  input  logic [N_CORES*DATA_W-1:0]   m_hwdata,
  output logic [N_CORES*DATA_W-1:0]   m_hrdata,
  output logic [N_CORES-1:0]          m_hready,
  output logic [N_CORES-1:0]          m_hresp,
  output logic [ADDR_W-1:0]           s_haddr,
  output logic                        s_hwrite,
  output logic [SIZE_W-1:0]           s_hsize,
  output logic [BURST_W-1:0]          s_hburst,
  output logic                        s_hmastlock,
  output logic [PROT_W-1:0]           s_hprot,
  output logic [TRANS_W-1:0]          s_htrans,
  output logic [DATA_W-1:0]           s_hwdata,
  input  logic [DATA_W-1:0]           s_hrdata,
  input  logic                        s_hready,
  input  logic                        s_hresp
);

  localparam logic [TRANS_W-1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [TRANS_W-1:0] HTRANS_NONSEQ = 2'b10;

  logic [ADDR_W-1:0]          haddr_a  [N_CORES];
  logic [SIZE_W-1:0]          hsize_a  [N_CORES];
  logic [DATA_W-1:0]          hwdata_a [N_CORES];
  logic [N_CORES-1:0]         req_c;
  logic [N_CORES-1:0]         own_c;
  logic [N_CORES-1:0]         blk_c;
  logic                       grant_valid_c;
  logic [CORE_IDX_WIDTH-1:0]  grant_c;
  logic [CORE_IDX_WIDTH-1:0]  scan_idx_c;

  logic [CORE_IDX_WIDTH-1:0]  rr_ptr_q,     rr_ptr_d;
  logic                       dp_valid_q,   dp_valid_d;
  logic [CORE_IDX_WIDTH-1:0]  dp_owner_q,   dp_owner_d;
  logic                       lock_valid_q, lock_valid_d;
  logic [CORE_IDX_WIDTH-1:0]  lock_owner_q, lock_owner_d;
  logic [N_CORES-1:0]         stash_valid_q, stash_valid_d;
  logic [N_CORES-1:0]         stash_resp_q,  stash_resp_d;
  logic [DATA_W-1:0]          stash_rdata_q [N_CORES];
  logic [DATA_W-1:0]          stash_rdata_d [N_CORES];

  // Unflatten master buses and decode requests.
  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      haddr_a[i]  = m_haddr[i*ADDR_W +: ADDR_W];
      hsize_a[i]  = m_hsize[i*SIZE_W +: SIZE_W];
      hwdata_a[i] = m_hwdata[i*DATA_W +: DATA_W];
      req_c[i]    = (m_htrans[i*TRANS_W +: TRANS_W] == HTRANS_NONSEQ);
    end
  end

  // Held address wins; otherwise scan from rr_ptr+1 upward (last hit in the loop is highest priority).
  always_comb begin
    grant_valid_c = 1'b0;
    grant_c       = '0;
    scan_idx_c    = '0;
    if (lock_valid_q) begin
      grant_valid_c = 1'b1;
      grant_c       = lock_owner_q;
    end else begin
      for (int unsigned k = 0; k < N_CORES; k++) begin
        scan_idx_c = CORE_IDX_WIDTH'((32'(rr_ptr_q) + N_CORES - k) % N_CORES);
        if (req_c[scan_idx_c]) begin
          grant_valid_c = 1'b1;
          grant_c       = scan_idx_c;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < N_CORES; i++) begin
      own_c[i] = grant_valid_c && (grant_c == CORE_IDX_WIDTH'(i));
      blk_c[i] = req_c[i] && !own_c[i];
    end
  end

  // Slave request side.
  always_comb begin
    s_htrans    = HTRANS_IDLE;
    s_haddr     = '0;
    s_hwrite    = 1'b0;
    s_hsize     = '0;
    s_hwdata    = '0;
    s_hburst    = '0;
    s_hmastlock = 1'b0;
    s_hprot     = '0;
    if (!reset) begin
      if (grant_valid_c) begin
        s_htrans = HTRANS_NONSEQ;
        s_haddr  = haddr_a[grant_c];
        s_hwrite = m_hwrite[grant_c];
        s_hsize  = hsize_a[grant_c];
      end
      if (dp_valid_q) begin
        s_hwdata = hwdata_a[dp_owner_q];
      end
    end
  end

  // Per-master response side; a stash presents as ready unless that master is mid-request.
  always_comb begin
    m_hready = '1;
    m_hresp  = '0;
    m_hrdata = '0;
    if (!reset) begin
      for (int i = 0; i < N_CORES; i++) begin
        if (blk_c[i]) begin
          m_hready[i] = 1'b0;
        end else if (own_c[i]) begin
          m_hready[i] = s_hready;
        end else if (stash_valid_q[i]) begin
          m_hready[i] = 1'b1;
        end else begin
          m_hready[i] = s_hready;
        end
        m_hrdata[i*DATA_W +: DATA_W] = stash_valid_q[i] ? stash_rdata_q[i] : s_hrdata;
        m_hresp[i]                   = stash_valid_q[i] ? stash_resp_q[i]  : s_hresp;
      end
    end
  end

  always_comb begin
    rr_ptr_d      = rr_ptr_q;
    dp_valid_d    = dp_valid_q;
    dp_owner_d    = dp_owner_q;
    lock_valid_d  = lock_valid_q;
    lock_owner_d  = lock_owner_q;
    stash_valid_d = stash_valid_q;
    stash_resp_d  = stash_resp_q;
    stash_rdata_d = stash_rdata_q;

    if (s_hready) begin
      dp_valid_d   = grant_valid_c;
      lock_valid_d = 1'b0;
      if (grant_valid_c) begin
        dp_owner_d = grant_c;
        rr_ptr_d   = grant_c;
      end
    end else begin
      lock_valid_d = grant_valid_c;
      if (grant_valid_c) begin
        lock_owner_d = grant_c;
      end
    end

    for (int i = 0; i < N_CORES; i++) begin
      if (stash_valid_q[i] && m_hready[i]) begin
        stash_valid_d[i] = 1'b0;
      end
    end

    // Owner is busy presenting a new address, so hold its completed response.
    if (dp_valid_q && s_hready && blk_c[dp_owner_q]) begin
      stash_valid_d[dp_owner_q] = 1'b1;
      stash_rdata_d[dp_owner_q] = s_hrdata;
      stash_resp_d[dp_owner_q]  = s_hresp;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      dp_valid_q    <= 1'b0;
      dp_owner_q    <= '0;
      lock_valid_q  <= 1'b0;
      lock_owner_q  <= '0;
      stash_valid_q <= '0;
      stash_resp_q  <= '0;
      for (int i = 0; i < N_CORES; i++) begin
        stash_rdata_q[i] <= '0;
      end
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      dp_valid_q    <= dp_valid_d;
      dp_owner_q    <= dp_owner_d;
      lock_valid_q  <= lock_valid_d;
      lock_owner_q  <= lock_owner_d;
      stash_valid_q <= stash_valid_d;
      stash_resp_q  <= stash_resp_d;
      stash_rdata_q <= stash_rdata_d;
    end
  end

endmodule
